// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding and branch target buffer entry/state types.
// ADDR_WIDTH defaults to 32 when the build does not supply it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    localparam int ADDR_W         = `ADDR_WIDTH;
    localparam int BTB_INDEX_BITS = 6;
    localparam int BTB_TAG_BITS   = 8;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } btb_state_e;

    localparam logic [1:0] BTB_CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] BTB_CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] BTB_CNT_WEAK_T    = 2'b10;
    localparam logic [1:0] BTB_CNT_STRONG_T  = 2'b11;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [1:0]              counter;
        logic [ADDR_W-1:0]       target;
    } btb_entry_t;

    // Two-bit saturating counter step: up on taken, down on not-taken.
    function automatic logic [1:0] sat_update(input logic [1:0] counter, input BranchOutcome outcome);
        if (outcome == TAKEN)
            return (counter == BTB_CNT_STRONG_T) ? counter : counter + 2'd1;
        return (counter == BTB_CNT_STRONG_NT) ? counter : counter - 2'd1;
    endfunction

`ifdef SIMULATION
    function automatic void stats_event(input string name);
        if (name.len() == 0) return;
    endfunction
`endif

endpackage

// File: rtl/branch_target_buffer_stats.sv
// Lookup/hit/target-miss event counters for the branch target buffer.
// Present only when BRANCH_TARGET_BUFFER_STATS_EN is defined.
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
module branch_target_buffer_stats
    import mips_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_fire,
    input  logic        hit,
    input  logic        target_miss,
    output logic [31:0] o_stat_lookups,
    output logic [31:0] o_stat_hits,
    output logic [31:0] o_stat_target_miss
);

    // Cleared by reset only; a table flush leaves the history intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_lookups     <= '0;
            o_stat_hits        <= '0;
            o_stat_target_miss <= '0;
        end else begin
            if (lookup_fire) o_stat_lookups     <= o_stat_lookups + 32'd1;
            if (hit)         o_stat_hits        <= o_stat_hits + 32'd1;
            if (target_miss) o_stat_target_miss <= o_stat_target_miss + 32'd1;
        end
    end

`ifdef SIMULATION
    always @(posedge clk) begin
        if (rst_n && lookup_fire) begin
            if (hit) stats_event("btb_hit");
            else     stats_event("btb_miss");
        end
    end
`endif

endmodule
`endif

// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged fetch-stage branch target buffer with 2-bit counters and an init sweep.
// Optional counters: define BRANCH_TARGET_BUFFER_STATS_EN.
module branch_target_buffer
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8,
    parameter int ADDR_W     = `ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_lookup_valid,
    input  logic [ADDR_W-1:0] i_lookup_pc,
    output logic              o_hit,
    output logic              o_predict_taken,
    output logic [ADDR_W-1:0] o_target,
    output logic              o_ready,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic [ADDR_W-1:0] i_upd_target,
    input  logic              i_upd_outcome,
    input  logic              i_upd_is_jump,
    input  logic              i_flush
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
    ,
    output logic [31:0]       o_stat_lookups,
    output logic [31:0]       o_stat_hits,
    output logic [31:0]       o_stat_target_miss
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [1:0]          counter;
        logic [ADDR_W-1:0]   target;
    } entry_t;

    localparam entry_t CLEAR_ENTRY = '{valid: 1'b0, tag: '0, counter: BTB_CNT_WEAK_NT, target: '0};

    btb_state_e            state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_idx_q, sweep_idx_d;
    entry_t                table_q [ENTRIES];

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    entry_t                wr_entry;

    logic [INDEX_BITS-1:0] lk_idx, upd_idx;
    logic [TAG_BITS-1:0]   lk_tag, upd_tag;
    entry_t                lk_entry, upd_entry;
    logic                  upd_tag_hit, upd_taken, upd_alloc;

    assign lk_idx    = i_lookup_pc[TAG_LO-1:2];
    assign lk_tag    = i_lookup_pc[TAG_HI:TAG_LO];
    assign lk_entry  = table_q[lk_idx];
    assign upd_idx   = i_upd_pc[TAG_LO-1:2];
    assign upd_tag   = i_upd_pc[TAG_HI:TAG_LO];
    assign upd_entry = table_q[upd_idx];

    assign upd_tag_hit = upd_entry.valid && (upd_entry.tag == upd_tag);
    assign upd_taken   = (BranchOutcome'(i_upd_outcome) == TAKEN);
    assign upd_alloc   = upd_taken || i_upd_is_jump;

    // Word-offset bits and bits above the tag field take no part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_lookup_pc[1:0], i_lookup_pc[ADDR_W-1:TAG_HI+1],
                              i_upd_pc[1:0], i_upd_pc[ADDR_W-1:TAG_HI+1]};

    assign o_ready         = (state_q == READY);
    assign o_hit           = o_ready && i_lookup_valid && lk_entry.valid && (lk_entry.tag == lk_tag);
    assign o_predict_taken = o_hit && lk_entry.counter[1];
    assign o_target        = o_hit ? lk_entry.target : '0;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        wr_en       = 1'b0;
        wr_idx      = sweep_idx_q;
        wr_entry    = CLEAR_ENTRY;
        case (state_q)
            INIT: begin
                wr_en = 1'b1;
                if (i_flush) begin
                    sweep_idx_d = '0;
                end else begin
                    sweep_idx_d = sweep_idx_q + 1'b1;
                    if (&sweep_idx_q) state_d = READY;
                end
            end
            READY: begin
                if (i_flush) begin
                    state_d     = INIT;
                    sweep_idx_d = '0;
                end else if (i_upd_valid) begin
                    wr_idx = upd_idx;
                    if (upd_tag_hit) begin
                        wr_en            = 1'b1;
                        wr_entry         = upd_entry;
                        wr_entry.counter = i_upd_is_jump ? BTB_CNT_STRONG_T
                                                         : sat_update(upd_entry.counter, BranchOutcome'(i_upd_outcome));
                        if (upd_alloc) wr_entry.target = i_upd_target;
                    end else if (upd_alloc) begin
                        wr_en    = 1'b1;
                        wr_entry = '{valid:   1'b1,
                                     tag:     upd_tag,
                                     counter: i_upd_is_jump ? BTB_CNT_STRONG_T : BTB_CNT_WEAK_T,
                                     target:  i_upd_target};
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // NOTE: the table has no reset; the INIT sweep clears it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_idx] <= wr_entry;
    end

`ifdef BRANCH_TARGET_BUFFER_STATS_EN
    branch_target_buffer_stats u_stats (
        .clk                (clk),
        .rst_n              (rst_n),
        .lookup_fire        (o_ready && i_lookup_valid),
        .hit                (o_hit),
        .target_miss        (o_ready && i_upd_valid && !i_flush && upd_tag_hit && upd_taken
                             && (upd_entry.target != i_upd_target)),
        .o_stat_lookups     (o_stat_lookups),
        .o_stat_hits        (o_stat_hits),
        .o_stat_target_miss (o_stat_target_miss)
    );
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (default 64-entry, 8-bit tag build).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_target_buffer;
    import mips_core_pkg::*;

    localparam int AW = `ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_lookup_valid = 1'b0;
    logic [AW-1:0] i_lookup_pc = '0;
    logic          o_hit, o_predict_taken, o_ready;
    logic [AW-1:0] o_target;
    logic          i_upd_valid = 1'b0;
    logic [AW-1:0] i_upd_pc = '0;
    logic [AW-1:0] i_upd_target = '0;
    logic          i_upd_outcome = 1'b0;
    logic          i_upd_is_jump = 1'b0;
    logic          i_flush = 1'b0;
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
    logic [31:0]   o_stat_lookups, o_stat_hits, o_stat_target_miss;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_target_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_lookup_valid  (i_lookup_valid),
        .i_lookup_pc     (i_lookup_pc),
        .o_hit           (o_hit),
        .o_predict_taken (o_predict_taken),
        .o_target        (o_target),
        .o_ready         (o_ready),
        .i_upd_valid     (i_upd_valid),
        .i_upd_pc        (i_upd_pc),
        .i_upd_target    (i_upd_target),
        .i_upd_outcome   (i_upd_outcome),
        .i_upd_is_jump   (i_upd_is_jump),
        .i_flush         (i_flush)
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
        ,
        .o_stat_lookups     (o_stat_lookups),
        .o_stat_hits        (o_stat_hits),
        .o_stat_target_miss (o_stat_target_miss)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Combinational lookup, checked 1 time unit after driving (away from clk edges).
    task automatic lookup(input string tag, input logic [AW-1:0] pc,
                          input logic exp_hit, input logic exp_taken, input logic [AW-1:0] exp_tgt);
        i_lookup_valid = 1'b1;
        i_lookup_pc    = pc;
        #1;
        check({tag, ".hit"},    64'(o_hit),           64'(exp_hit));
        check({tag, ".taken"},  64'(o_predict_taken), 64'(exp_taken));
        check({tag, ".target"}, 64'(o_target),        64'(exp_tgt));
        i_lookup_valid = 1'b0;
    endtask

    // Presents one update across a single rising edge.
    task automatic update(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                          input logic outcome, input logic jump);
        i_upd_valid   = 1'b1;
        i_upd_pc      = pc;
        i_upd_target  = tgt;
        i_upd_outcome = outcome;
        i_upd_is_jump = jump;
        @(negedge clk);
        i_upd_valid   = 1'b0;
        i_upd_is_jump = 1'b0;
    endtask

    // Called right after entering INIT with sweep_idx = 0; counts edges until o_ready.
    task automatic expect_init(input string tag);
        int cyc = 0;
        while (!o_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".init_cycles"}, 64'(cyc), 64'd64);
    endtask

    initial begin
        // Reset state
        #12;
        i_lookup_valid = 1'b1;
        i_lookup_pc    = AW'(32'h100);
        #1;
        check("rst.ready",  64'(o_ready),         64'd0);
        check("rst.hit",    64'(o_hit),           64'd0);
        check("rst.taken",  64'(o_predict_taken), 64'd0);
        check("rst.target", 64'(o_target),        64'd0);
        i_lookup_valid = 1'b0;

        // 1: power-on sweep takes 64 cycles, lookups ignored meanwhile
        @(negedge clk);
        rst_n = 1'b1;
        lookup("init_lookup", AW'(32'h100), 1'b0, 1'b0, '0);
        expect_init("por");

        // 2: allocate on taken branch
        update(AW'(32'h100), AW'(32'h200), TAKEN, 1'b0);
        lookup("alloc",      AW'(32'h100),   1'b1, 1'b1, AW'(32'h200));
        lookup("next_index", AW'(32'h104),   1'b0, 1'b0, '0);
        lookup("low_bits",   AW'(32'h103),   1'b1, 1'b1, AW'(32'h200));
        lookup("above_tag",  AW'(32'h10100), 1'b1, 1'b1, AW'(32'h200));

        // 3: counter walk 10 -> 01 -> 00 -> 01 -> 10 -> 11 (saturate) -> 10
        update(AW'(32'h100), AW'(32'h999), NOT_TAKEN, 1'b0);
        update(AW'(32'h100), AW'(32'h999), NOT_TAKEN, 1'b0);
        lookup("cnt00", AW'(32'h100), 1'b1, 1'b0, AW'(32'h200));
        update(AW'(32'h100), AW'(32'h200), TAKEN, 1'b0);
        lookup("cnt01", AW'(32'h100), 1'b1, 1'b0, AW'(32'h200));
        update(AW'(32'h100), AW'(32'h204), TAKEN, 1'b0);
        lookup("cnt10", AW'(32'h100), 1'b1, 1'b1, AW'(32'h204));
        repeat (5) update(AW'(32'h100), AW'(32'h204), TAKEN, 1'b0);
        update(AW'(32'h100), AW'(32'h204), NOT_TAKEN, 1'b0);
        lookup("sat11_dec", AW'(32'h100), 1'b1, 1'b1, AW'(32'h204));

        // 4: aliasing pc (same index, tag 0x02) replaces the entry
        update(AW'(32'h200), AW'(32'h300), TAKEN, 1'b0);
        lookup("alias_old", AW'(32'h100), 1'b0, 1'b0, '0);
        lookup("alias_new", AW'(32'h200), 1'b1, 1'b1, AW'(32'h300));

        // 5: no allocation on not-taken miss; jump allocates strongly taken
        update(AW'(32'h108), AW'(32'h500), NOT_TAKEN, 1'b0);
        lookup("nt_miss", AW'(32'h108), 1'b0, 1'b0, '0);
        update(AW'(32'h10C), AW'(32'h40), TAKEN, 1'b1);
        lookup("jump", AW'(32'h10C), 1'b1, 1'b1, AW'(32'h40));
        update(AW'(32'h10C), AW'(32'h40), NOT_TAKEN, 1'b0);
        lookup("jump_cnt11", AW'(32'h10C), 1'b1, 1'b1, AW'(32'h40));

        // Same-cycle lookup and update: lookup sees the old counter (10), update lands next cycle (01)
        i_lookup_valid = 1'b1;
        i_lookup_pc    = AW'(32'h10C);
        i_upd_valid    = 1'b1;
        i_upd_pc       = AW'(32'h10C);
        i_upd_target   = AW'(32'h40);
        i_upd_outcome  = NOT_TAKEN;
        i_upd_is_jump  = 1'b0;
        #1;
        check("same_cycle.taken", 64'(o_predict_taken), 64'd1);
        @(negedge clk);
        i_upd_valid = 1'b0;
        lookup("after_same_cycle", AW'(32'h10C), 1'b1, 1'b0, AW'(32'h40));

        // 6: flush in READY with a simultaneous update, then flush again mid-sweep at index 30
        i_flush = 1'b1;
        update(AW'(32'h300), AW'(32'h600), TAKEN, 1'b0);
        i_flush = 1'b0;
        check("flush.ready_low", 64'(o_ready), 64'd0);
        repeat (30) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        repeat (63) @(negedge clk);
        check("resweep.last_init", 64'(o_ready), 64'd0);
        update(AW'(32'hF8), AW'(32'h700), TAKEN, 1'b0);
        check("resweep.ready", 64'(o_ready), 64'd1);
        lookup("flushed_200",   AW'(32'h200), 1'b0, 1'b0, '0);
        lookup("flushed_10c",   AW'(32'h10C), 1'b0, 1'b0, '0);
        lookup("flushed_300",   AW'(32'h300), 1'b0, 1'b0, '0);
        lookup("init_upd_drop", AW'(32'hF8),  1'b0, 1'b0, '0);

        // Asynchronous reset drops outputs without a clock edge
        update(AW'(32'h10C), AW'(32'h40), TAKEN, 1'b1);
        i_lookup_valid = 1'b1;
        i_lookup_pc    = AW'(32'h10C);
        #1;
        check("pre_rst.hit", 64'(o_hit), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.ready",  64'(o_ready),  64'd0);
        check("async_rst.hit",    64'(o_hit),    64'd0);
        check("async_rst.target", 64'(o_target), 64'd0);
        i_lookup_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset pulse mid-sweep restarts the full 64-cycle sweep
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_sweep_rst.ready", 64'(o_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_init("mid_sweep_rst");
        lookup("post_rst", AW'(32'h10C), 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
